// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter: default sizes,
// FSM state encoding and the hardwired-zero register address.
package reg_write_arbiter_pkg;
    localparam int NREQ_DEF = 4;
    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 32;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Register 0 reads as zero; writes aimed at it are consumed but dropped.
    localparam int ZERO_REG_ADDR = 0;
endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Rotating priority encoder: the first set bit of req, searching from ptr
// upward with wrap, becomes a one-hot grant plus its index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx,
    output logic            valid
);
    int j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!valid && req[j]) begin
                valid  = 1'b1;
                idx    = PW'(j);
                gnt[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single register-file write port; the winning
// address/data are registered one cycle after the grant.
// Optional grant locking is built when ARB_LOCK_EN is defined.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_lock,
    output logic [NREQ-1:0]    gnt,
    output logic               wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [DW-1:0]      wr_data,
    output logic               busy,
    output logic               dbg_state,
    output logic [PW-1:0]      dbg_ptr
);
    // Handshake: req[i] stays high until a rising edge samples gnt[i]=1,
    // which consumes the write; the requester may change req afterwards.

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_next;
    logic            ptr_load;
    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            pick_valid;
    logic [NREQ-1:0] sel_gnt;
    logic [PW-1:0]   sel_idx;
    logic            sel_valid;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            wr_load;
    logic [0:0]      state;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef ARB_LOCK_EN
    logic [PW-1:0] owner;

    // While locked only the owner may win; other requesters wait.
    always_comb begin
        sel_gnt   = pick_gnt;
        sel_idx   = pick_idx;
        sel_valid = pick_valid;
        if (state == ST_LOCKED) begin
            sel_gnt        = '0;
            sel_idx        = owner;
            sel_valid      = req[owner];
            sel_gnt[owner] = req[owner];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            owner <= '0;
        end else if (state == ST_IDLE) begin
            if (sel_valid && req_lock[sel_idx]) begin
                state <= ST_LOCKED;
                owner <= sel_idx;
            end
        end else if (!req[owner] || !req_lock[owner]) begin
            state <= ST_IDLE;
        end
    end

    // Pointer is frozen while the lock is held and moves past the owner on release.
    assign ptr_load = (state == ST_IDLE) ? sel_valid : (!req[owner] || !req_lock[owner]);
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign state       = ST_IDLE;
    assign sel_gnt     = pick_gnt;
    assign sel_idx     = pick_idx;
    assign sel_valid   = pick_valid;
    assign ptr_load    = sel_valid;
`endif

    assign ptr_next = (int'(sel_idx) == NREQ - 1) ? '0 : sel_idx + PW'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (ptr_load) begin
            ptr <= ptr_next;
        end
    end

    assign sel_addr = req_addr[sel_idx*AW +: AW];
    assign sel_data = req_data[sel_idx*DW +: DW];
    assign wr_load  = sel_valid && (sel_addr != AW'(ZERO_REG_ADDR));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_en <= 1'b0;
        end else begin
            wr_en <= wr_load;
        end
    end

    // Enable-gated address/data register: holds its value when nothing loads.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_addr <= '0;
            wr_data <= '0;
        end else if (wr_load) begin
            wr_addr <= sel_addr;
            wr_data <= sel_data;
        end
    end

    assign gnt       = reset ? sel_gnt : '0;
    assign busy      = |req;
    assign dbg_state = state;
    assign dbg_ptr   = ptr;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: vector table plus hand-written
// reset, mid-operation reset and (with ARB_LOCK_EN) lock sequences.
module tb_reg_write_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic               clock = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ-1:0]    gnt;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic               busy;
    logic               dbg_state;
    logic [1:0]         dbg_ptr;

    int checks   = 0;
    int failures = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] sb_exp;

    typedef struct {
        logic [3:0]  req;
        logic        zero1;
        logic [3:0]  gnt;
        logic        wr_en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  ptr;
    } vec_t;

    vec_t vecs[17];

    reg_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .gnt       (gnt),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    // clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Requester 1 can be pointed at register 0 to exercise the dropped write.
    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic z1);
        req      = r;
        req_lock = l;
        req_addr = {5'd31, 5'd7, (z1 ? 5'd0 : 5'd9), 5'd3};
        req_data = {32'h44443333, 32'hDEADBEEF, 32'h12345678, 32'h11110000};
    endtask

    // One cycle: drive after negedge, check gnt, then check registered outputs after the edge.
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] l,
                        input logic z1, input logic [3:0] eg, input logic ewe,
                        input logic [4:0] ea, input logic [31:0] ed,
                        input logic [1:0] ep, input logic es);
        drive(r, l, z1);
        #1;
        check($sformatf("%s.gnt", tag), 64'(gnt), 64'(eg));
        check($sformatf("%s.busy", tag), 64'(busy), 64'(|r));
        if (ewe) exp_q.push_back({ea, ed});
        @(posedge clock);
        #1;
        check($sformatf("%s.wr_en", tag), 64'(wr_en), 64'(ewe));
        check($sformatf("%s.wr_addr", tag), 64'(wr_addr), 64'(ea));
        check($sformatf("%s.wr_data", tag), 64'(wr_data), 64'(ed));
        check($sformatf("%s.ptr", tag), 64'(dbg_ptr), 64'(ep));
        check($sformatf("%s.state", tag), 64'(dbg_state), 64'(es));
        @(negedge clock);
    endtask

    // scoreboard: every observed write must match the oldest expected one
    always @(negedge clock) begin
        if (reset === 1'b1 && wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%0h expected=none", {wr_addr, wr_data});
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_write", 64'({wr_addr, wr_data}), 64'(sb_exp));
            end
        end
    end

    initial begin
        vecs[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 5'd0,  32'h00000000, 2'd0};
        vecs[1]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 5'd7,  32'hDEADBEEF, 2'd3};
        vecs[2]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 5'd31, 32'h44443333, 2'd0};
        vecs[3]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 5'd3,  32'h11110000, 2'd1};
        vecs[4]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 5'd9,  32'h12345678, 2'd2};
        vecs[5]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 5'd7,  32'hDEADBEEF, 2'd3};
        vecs[6]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 5'd31, 32'h44443333, 2'd0};
        vecs[7]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 5'd3,  32'h11110000, 2'd1};
        vecs[8]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 5'd9,  32'h12345678, 2'd2};
        vecs[9]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 5'd7,  32'hDEADBEEF, 2'd3};
        vecs[10] = '{4'b1111, 1'b0, 4'b1000, 1'b1, 5'd31, 32'h44443333, 2'd0};
        vecs[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 5'd31, 32'h44443333, 2'd0};
        vecs[12] = '{4'b0010, 1'b1, 4'b0010, 1'b0, 5'd31, 32'h44443333, 2'd2};
        vecs[13] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 5'd31, 32'h44443333, 2'd0};
        vecs[14] = '{4'b0011, 1'b0, 4'b0001, 1'b1, 5'd3,  32'h11110000, 2'd1};
        vecs[15] = '{4'b0011, 1'b0, 4'b0010, 1'b1, 5'd9,  32'h12345678, 2'd2};
        vecs[16] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 5'd3,  32'h11110000, 2'd1};

        // reset held with every requester active
        reset = 1'b0;
        drive(4'b1111, 4'b0000, 1'b0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst.gnt", 64'(gnt), 64'd0);
        check("rst.wr_en", 64'(wr_en), 64'd0);
        check("rst.wr_addr", 64'(wr_addr), 64'd0);
        check("rst.wr_data", 64'(wr_data), 64'd0);
        check("rst.ptr", 64'(dbg_ptr), 64'd0);
        check("rst.state", 64'(dbg_state), 64'd0);
        drive(4'b0000, 4'b0000, 1'b0);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 17; i++) begin
            step($sformatf("vec%0d", i), vecs[i].req, 4'b0000, vecs[i].zero1,
                 vecs[i].gnt, vecs[i].wr_en, vecs[i].addr, vecs[i].data,
                 vecs[i].ptr, 1'b0);
        end

        // reset lands right after requester 1 was granted: the write is lost
        drive(4'b0010, 4'b0000, 1'b0);
        #1;
        check("midrst.gnt", 64'(gnt), 64'b0010);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("midrst.wr_en", 64'(wr_en), 64'd0);
        check("midrst.gnt_forced", 64'(gnt), 64'd0);
        check("midrst.ptr", 64'(dbg_ptr), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        step("postrst", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 5'd0, 32'h0, 2'd0, 1'b0);

`ifdef ARB_LOCK_EN
        step("lock1", 4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1, 5'd31, 32'h44443333, 2'd0, 1'b1);
        step("lock2", 4'b1001, 4'b1000, 1'b0, 4'b1000, 1'b1, 5'd31, 32'h44443333, 2'd0, 1'b1);
        step("lock3", 4'b1001, 4'b1000, 1'b0, 4'b1000, 1'b1, 5'd31, 32'h44443333, 2'd0, 1'b1);
        step("lock4", 4'b1001, 4'b0000, 1'b0, 4'b1000, 1'b1, 5'd31, 32'h44443333, 2'd0, 1'b0);
        step("lock5", 4'b1001, 4'b0000, 1'b0, 4'b0001, 1'b1, 5'd3,  32'h11110000, 2'd1, 1'b0);
        step("lock6", 4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 5'd7,  32'hDEADBEEF, 2'd3, 1'b1);
        step("lock7", 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 5'd7,  32'hDEADBEEF, 2'd3, 1'b0);
        step("lock8", 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 5'd3,  32'h11110000, 2'd1, 1'b0);
`endif

        // final report
        drive(4'b0000, 4'b0000, 1'b0);
        @(negedge clock);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin arbiter sharing the single write port of the 32-entry register file (bank of 32-bit enable-gated registers) among several requesters: CPU writeback, game-logic engine, input/controller block, debug loader. Each cycle at most one requester is granted; the granted address/data are registered and presented to the register file's decoder and enable lines one cycle later. Sits between the requesters and the register file.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 5, register address width
- DW, 32, data width
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester write request, held until granted
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_data  in  NREQ*DW  packed data, requester i at [i*DW +: DW]
- req_lock  in  NREQ  hold grant across consecutive writes (only with ARB_LOCK_EN; otherwise ignored)
- gnt  out  NREQ  one-hot grant, combinational, same cycle as accept
- wr_en  out  1  register file write enable (registered)
- wr_addr  out  AW  register file write address (registered)
- wr_data  out  DW  register file write data (registered)
- busy  out  1  high when any req is high this cycle

## Operation
- Round-robin pointer ptr (log2 NREQ bits) names the highest-priority requester; search order ptr, ptr+1, ... wrapping modulo NREQ.
- Grant: first requester in search order with req=1; gnt one-hot for that index; gnt all-zero when no req.
- On a grant to index k: ptr <= (k+1) mod NREQ at the clock edge; if req_addr_k == 0, wr_en <= 0 (register 0 is hardwired zero, write dropped but request still consumed); otherwise wr_en <= 1, wr_addr <= req_addr_k, wr_data <= req_data_k.
- No grant: wr_en <= 0; wr_addr/wr_data hold previous values.
- Requester i treats gnt[i]=1 at a rising edge as consumption; it may change or drop req on the following cycle.
- Dropping req without grant is permitted; no state is retained for it.
- FSM (two states): IDLE (no lock held) and LOCKED(owner). Without ARB_LOCK_EN the block stays in IDLE.

## Timing
- Reset (reset=0, asynchronous): ptr=0, state=IDLE, wr_en=0, wr_addr=0, wr_data=0; gnt forced to all-zero while reset is low.
- Latency: req accepted in cycle n -> wr_en/wr_addr/wr_data valid during cycle n+1; register file captures at end of n+1.
- Throughput: one write per cycle, back-to-back grants to different requesters allowed.
- Fairness: with all NREQ requesting continuously, each is granted exactly once per NREQ cycles.
- ptr wrap: grant to NREQ-1 sets ptr=0.
- Reset asserted mid-operation: in-flight registered write is discarded (wr_en cleared immediately); granted requester's transaction is considered lost.

## Configuration
- ARB_LOCK_EN defined: a grant to k with req_lock_k=1 moves IDLE->LOCKED(k); in LOCKED, only k can be granted while req_k=1, ptr frozen; LOCKED->IDLE on the first cycle k is granted with req_lock_k=0, or when req_k=0 (no grant that cycle to k; others arbitrate normally from the next cycle), with ptr <= (k+1) mod NREQ.
- ARB_LOCK_EN undefined: req_lock ignored, no LOCKED state, pure round robin.

## Structure
- Shared package/header: NREQ, AW, DW defaults, FSM state encoding (IDLE, LOCKED), zero-register address constant.
- One sub-module: rr_pick (combinational rotate-priority-encoder: req vector + ptr -> one-hot gnt + index + valid).
- Output register built from the team's enable-gated flop cells.

## Test plan
- Reset: hold reset=0 with req=4'b1111 -> gnt=0, wr_en=0, wr_addr=0, wr_data=0.
- Single request: req[2]=1, addr=7, data=32'hDEADBEEF -> gnt=4'b0100 same cycle; next cycle wr_en=1, wr_addr=7, wr_data=32'hDEADBEEF; ptr=3.
- Full contention: req=4'b1111 for 8 cycles from ptr=0 -> grant sequence 0,1,2,3,0,1,2,3.
- Zero register: req[1]=1, addr=0, data=32'h12345678 -> gnt[1]=1; next cycle wr_en=0.
- Lock (ARB_LOCK_EN): req[3] with lock=1 for 3 writes while req[0] held -> gnt[3] three cycles, then lock=0 write, then gnt[0].
- Mid-op reset: grant req[1], assert reset before next edge -> wr_en stays 0, ptr=0 after release.
